fetch_ctrl: RTL

//  Sequencer for the instruction-fetch stage: drives fetch en/jmp/jmp_addr and the IF/ID squash.

---
 rtl/fetch_ctrl_if.sv | 34 +++
 rtl/fetch_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Purpose : bundles the fetch-stage sequencing signals between fetch_ctrl and its neighbours.
// Latency : n/a (wires only).
// Backpressure: stall_req from decode; fetch_ctrl honours it combinationally.
//
// Ports (master = fetch_ctrl, slave = fetch/decode/EX/debug side):
//   stall_req, br_taken, br_target, trap, halt, resume   -> into fetch_ctrl
//   fetch_en, fetch_jmp, fetch_jmp_addr, flush, if_valid,
//   redirect_cnt                                          <- out of fetch_ctrl
interface fetch_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_req;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            trap;
    logic            halt;
    logic            resume;
    logic            fetch_en;
    logic            fetch_jmp;
    logic [XLEN-1:0] fetch_jmp_addr;
    logic            flush;
    logic            if_valid;
    logic [15:0]     redirect_cnt;

    modport master (
        input  stall_req, br_taken, br_target, trap, halt, resume,
        output fetch_en, fetch_jmp, fetch_jmp_addr, flush, if_valid, redirect_cnt
    );

    modport slave (
        output stall_req, br_taken, br_target, trap, halt, resume,
        input  fetch_en, fetch_jmp, fetch_jmp_addr, flush, if_valid, redirect_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Purpose : fetch-stage sequencer; arbitrates trap / branch / boot redirects, debug halt, decode stall.
// Latency : outputs are combinational from state + inputs; redirects take effect the same cycle.
// Backpressure: stall_req drops fetch_en in RUN only; ignored during BOOT/FLUSH, irrelevant in HALT.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_ctrl_if.master (requests in, fetch controls / squash / redirect count out)
module fetch_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VEC    = '0,
    parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(32'h100),
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int unsigned    FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
    // The redirect cycle itself is the first flush cycle, so a single-cycle
    // flush goes straight back to RUN.
    localparam state_t         AFTER_REDIR = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t          state_q,         state_d;
    logic [FCW-1:0]  flush_cnt_q,     flush_cnt_d;
    logic            pending_valid_q, pending_valid_d;
    logic [XLEN-1:0] pending_addr_q,  pending_addr_d;
    logic [15:0]     redirect_cnt_q,  redirect_cnt_d;

    logic            fetch_en;
    logic            fetch_jmp;
    logic [XLEN-1:0] fetch_jmp_addr;
    logic            flush;
    logic            if_valid;
    logic            redir;
    logic [XLEN-1:0] redir_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= BOOT;
            flush_cnt_q     <= '0;
            pending_valid_q <= 1'b0;
            pending_addr_q  <= '0;
            redirect_cnt_q  <= '0;
        end else begin
            state_q         <= state_d;
            flush_cnt_q     <= flush_cnt_d;
            pending_valid_q <= pending_valid_d;
            pending_addr_q  <= pending_addr_d;
            redirect_cnt_q  <= redirect_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        pending_valid_d = pending_valid_q;
        pending_addr_d  = pending_addr_q;
        redirect_cnt_d  = redirect_cnt_q;
        fetch_en        = 1'b0;
        fetch_jmp       = 1'b0;
        fetch_jmp_addr  = RESET_VEC;
        flush           = 1'b0;
        if_valid        = 1'b0;
        redir           = 1'b0;
        redir_addr      = RESET_VEC;

        if (rst) begin
            // Registers are already forced by the async reset; only the
            // outputs need to show the reset values while rst is high.
            flush = 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    fetch_en    = 1'b1;
                    fetch_jmp   = 1'b1;
                    flush       = 1'b1;
                    state_d     = AFTER_REDIR;
                    flush_cnt_d = FLUSH_INIT;
                end

                RUN: begin
                    if (bus.trap) begin
                        redir      = 1'b1;
                        redir_addr = TRAP_VEC;
                    end else if (bus.br_taken) begin
                        redir      = 1'b1;
                        redir_addr = bus.br_target;
                    end else if (bus.halt) begin
                        // Instruction already in IF/ID still drains to decode.
                        if_valid = 1'b1;
                        state_d  = HALT;
                    end else begin
                        fetch_en = ~bus.stall_req;
                        if_valid = 1'b1;
                    end
                end

                FLUSH: begin
                    if (bus.trap) begin
                        redir      = 1'b1;
                        redir_addr = TRAP_VEC;
                    end else if (bus.br_taken) begin
                        redir      = 1'b1;
                        redir_addr = bus.br_target;
                    end else begin
                        // halt and stall_req are not looked at until RUN.
                        fetch_en    = 1'b1;
                        flush       = 1'b1;
                        flush_cnt_d = flush_cnt_q - 1'b1;
                        if (flush_cnt_q <= FCW'(1)) begin
                            state_d = RUN;
                        end
                    end
                end

                HALT: begin
                    if (bus.trap) begin
                        redir      = 1'b1;
                        redir_addr = TRAP_VEC;
                    end else if (bus.resume) begin
                        pending_valid_d = 1'b0;
                        if (bus.br_taken) begin
                            redir      = 1'b1;
                            redir_addr = bus.br_target;
                        end else if (pending_valid_q) begin
                            redir      = 1'b1;
                            redir_addr = pending_addr_q;
                        end else begin
                            fetch_en = 1'b1;
                            state_d  = RUN;
                        end
                    end else if (bus.br_taken) begin
                        // Remember the latest branch so resume can honour it.
                        pending_valid_d = 1'b1;
                        pending_addr_d  = bus.br_target;
                    end
                end

                default: begin
                    state_d = BOOT;
                end
            endcase

            if (redir) begin
                fetch_en        = 1'b1;
                fetch_jmp       = 1'b1;
                fetch_jmp_addr  = redir_addr;
                flush           = 1'b1;
                if_valid        = 1'b0;
                state_d         = AFTER_REDIR;
                flush_cnt_d     = FLUSH_INIT;
                pending_valid_d = 1'b0;
                if (redirect_cnt_q != 16'hFFFF) begin
                    redirect_cnt_d = redirect_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.fetch_en       = fetch_en;
    assign bus.fetch_jmp      = fetch_jmp;
    assign bus.fetch_jmp_addr = fetch_jmp_addr;
    assign bus.flush          = flush;
    assign bus.if_valid       = if_valid;
    assign bus.redirect_cnt   = redirect_cnt_q;

endmodule
